// File: rtl/clock_step_ctrl_if.sv
// Manual clock controls in, CPU advance enable and status out.
interface clock_step_ctrl_if #(
    parameter int unsigned DIV_WIDTH = 4
);
    logic                 push;
    logic                 mode;
    logic                 hlt;
    logic [DIV_WIDTH-1:0] div;
    logic                 tick;
    logic                 halted;
    logic [7:0]           tick_count;

    modport master (
        output push, mode, hlt, div,
        input  tick, halted, tick_count
    );

    modport slave (
        input  push, mode, hlt, div,
        output tick, halted, tick_count
    );
endinterface

// File: rtl/clock_step_ctrl.sv
// CPU clock-step controller: debounced single-step, divided free-run, sticky halt.
module clock_step_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DIV_WIDTH       = 4
) (
    input  logic             clk,
    input  logic             rst,
    clock_step_ctrl_if.slave bus
);

    localparam int unsigned DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_STEP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    logic                 sync_a;
    logic                 push_s;
    logic                 deb;
    logic                 deb_q;
    logic [DEB_W-1:0]     deb_cnt;
    logic                 press;

    state_t               state;
    state_t               state_next;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [DIV_WIDTH-1:0] div_cnt_next;
    logic                 tick_q;
    logic                 tick_next;
    logic                 halted_q;
    logic [7:0]           tick_count_q;

    // Two-flop synchronizer for the asynchronous push button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            push_s <= 1'b0;
        end else begin
            sync_a <= bus.push;
            push_s <= sync_a;
        end
    end

    // Debouncer: level flips only after an unbroken run of mismatching samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb     <= 1'b0;
            deb_q   <= 1'b0;
            deb_cnt <= '0;
        end else begin
            deb_q <= deb;
            if (push_s == deb) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DEB_LAST) begin
                deb     <= ~deb;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + DEB_W'(1);
            end
        end
    end

    // Rising edge of the debounced level is a press; releases are ignored.
    assign press = deb & ~deb_q;

    // State, divider and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_STEP;
            div_cnt  <= '0;
            tick_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_cnt_next;
            tick_q   <= tick_next;
            halted_q <= (state_next == ST_HALTED);
        end
    end

    // Next state and tick decision; halt outranks mode changes and ticks.
    always_comb begin
        state_next   = state;
        div_cnt_next = div_cnt;
        tick_next    = 1'b0;
        case (state)
            ST_STEP: begin
                div_cnt_next = '0;
                if (bus.hlt) begin
                    state_next = ST_HALTED;
                end else if (bus.mode) begin
                    state_next = ST_RUN;
                end else begin
                    tick_next = press;
                end
            end
            ST_RUN: begin
                if (bus.hlt) begin
                    state_next   = ST_HALTED;
                    div_cnt_next = '0;
                end else if (!bus.mode) begin
                    state_next   = ST_STEP;
                    div_cnt_next = '0;
                end else if (div_cnt == bus.div) begin
                    tick_next    = 1'b1;
                    div_cnt_next = '0;
                end else begin
                    // Wraps through the maximum when div shrinks below the count.
                    div_cnt_next = div_cnt + DIV_WIDTH'(1);
                end
            end
            ST_HALTED: begin
                div_cnt_next = '0;
            end
            default: begin
                state_next   = ST_STEP;
                div_cnt_next = '0;
            end
        endcase
    end

    // Running count of issued ticks, modulo 256.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_count_q <= 8'd0;
        end else begin
            tick_count_q <= tick_count_q + {7'd0, tick_q};
        end
    end

    assign bus.tick       = tick_q;
    assign bus.halted     = halted_q;
    assign bus.tick_count = tick_count_q;

endmodule

// File: tb/tb_clock_step_ctrl.sv
// Bench for clock_step_ctrl: behavioural model checked every cycle plus directed literal pins.
module tb_clock_step_ctrl;

    localparam int DEB = 4;
    localparam int DW  = 4;

    logic clk;
    logic rst;

    clock_step_ctrl_if #(.DIV_WIDTH(DW)) bus ();

    clock_step_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .DIV_WIDTH      (DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int tick_seen = 0;
    int first_tick = -1;
    int mark = 0;
    int base = 0;

    // Model state
    bit m_s1, m_s2, m_deb, m_debq;
    bit m_run, m_halt;
    int m_phase;
    bit hist[$];
    bit exp_tick;
    bit exp_halted;
    int exp_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Spec-level model: deb flips once the last DEB synchronized samples all
    // disagree with it; run mode ticks after div+1 edges of uninterrupted run.
    always @(posedge clk or posedge rst) begin : model
        bit p;
        bit nt;
        bit all_diff;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_deb = 0; m_debq = 0;
            m_run = 0; m_halt = 0; m_phase = 0;
            hist.delete();
            exp_tick = 0; exp_halted = 0; exp_count = 0;
        end else begin
            p  = m_deb && !m_debq;
            nt = 0;
            exp_count = (exp_count + int'(exp_tick)) % 256;
            if (m_halt) begin
                nt = 0;
            end else if (bus.hlt) begin
                m_halt = 1;
            end else if (m_run != bus.mode) begin
                m_run   = bus.mode;
                m_phase = 0;
            end else if (m_run) begin
                if (m_phase == int'(bus.div)) begin
                    nt      = 1;
                    m_phase = 0;
                end else begin
                    m_phase = (m_phase + 1) % (1 << DW);
                end
            end else begin
                nt = p;
            end
            exp_tick   = nt;
            exp_halted = m_halt;
            hist.push_back(m_s2);
            if (hist.size() > DEB) void'(hist.pop_front());
            m_debq = m_deb;
            if (hist.size() == DEB) begin
                all_diff = 1;
                foreach (hist[i]) if (hist[i] == m_deb) all_diff = 0;
                if (all_diff) m_deb = !m_deb;
            end
            m_s2 = m_s1;
            m_s1 = bus.push;
        end
    end

    // Compare DUT against the model just after every active edge.
    always @(posedge clk) begin
        #1;
        if (!rst) begin
            check("tick", int'(bus.tick), int'(exp_tick));
            check("halted", int'(bus.halted), int'(exp_halted));
            check("tick_count", int'(bus.tick_count), exp_count);
            if (bus.tick) begin
                tick_seen++;
                if (first_tick < mark) first_tick = cyc;
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_hold(input int n);
        mark = cyc + 1;
        bus.push = 1'b1;
        wait_cycles(n);
        bus.push = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.push = 1'b0;
        bus.mode = 1'b0;
        bus.hlt  = 1'b0;
        bus.div  = '0;
        wait_cycles(3);
        check("reset_tick", int'(bus.tick), 0);
        check("reset_halted", int'(bus.halted), 0);
        check("reset_count", int'(bus.tick_count), 0);
        rst = 1'b0;
        wait_cycles(2);

        // Clean presses in STEP mode
        base = tick_seen;
        press_hold(20);
        check("press1_latency", first_tick - mark, 6);
        check("press1_ticks", tick_seen - base, 1);
        wait_cycles(10);
        check("press1_count", int'(bus.tick_count), 1);
        press_hold(20);
        wait_cycles(10);
        check("press2_count", int'(bus.tick_count), 2);

        // Bounce: 2-cycle pulses, then a stable hold
        base = tick_seen;
        for (int i = 0; i < 6; i++) begin
            bus.push = (i % 2 == 0);
            wait_cycles(2);
        end
        check("bounce_no_tick", tick_seen - base, 0);
        press_hold(20);
        check("bounce_latency", first_tick - mark, 6);
        check("bounce_ticks", tick_seen - base, 1);
        wait_cycles(10);
        check("bounce_count", int'(bus.tick_count), 3);

        // RUN with div=3, button pressed mid-run
        bus.div  = 4'd3;
        bus.mode = 1'b1;
        mark = cyc + 1;
        base = tick_seen;
        wait_cycles(10);
        bus.push = 1'b1;
        wait_cycles(20);
        bus.push = 1'b0;
        wait_cycles(11);
        bus.mode = 1'b0;
        wait_cycles(10);
        check("run3_first", first_tick - mark, 4);
        check("run3_ticks", tick_seen - base, 10);
        check("run3_count", int'(bus.tick_count), 13);

        // div shrinks below the current count: wraps through 15
        bus.div  = 4'd7;
        bus.mode = 1'b1;
        mark = cyc + 1;
        base = tick_seen;
        wait_cycles(6);
        bus.div = 4'd2;
        wait_cycles(20);
        bus.mode = 1'b0;
        wait_cycles(5);
        check("divchg_first", first_tick - mark, 19);
        check("divchg_ticks", tick_seen - base, 3);
        check("divchg_count", int'(bus.tick_count), 16);

        // div=0 ticks every cycle, then reset mid-cycle
        bus.div  = 4'd0;
        bus.mode = 1'b1;
        base = tick_seen;
        wait_cycles(11);
        check("div0_ticks", tick_seen - base, 10);
        check("div0_tick_high", int'(bus.tick), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tick", int'(bus.tick), 0);
        check("async_rst_halted", int'(bus.halted), 0);
        check("async_rst_count", int'(bus.tick_count), 0);
        @(negedge clk);
        bus.mode = 1'b0;
        rst = 1'b0;
        wait_cycles(2);

        // 256 ticks wrap the counter
        bus.div  = 4'd0;
        bus.mode = 1'b1;
        base = tick_seen;
        wait_cycles(257);
        check("wrap_count_255", int'(bus.tick_count), 255);
        bus.mode = 1'b0;
        wait_cycles(3);
        check("wrap_ticks", tick_seen - base, 256);
        check("wrap_count_0", int'(bus.tick_count), 0);

        // Halt on a due tick, then presses and mode toggles are ignored
        bus.div  = 4'd2;
        bus.mode = 1'b1;
        base = tick_seen;
        wait_cycles(6);
        bus.hlt = 1'b1;
        wait_cycles(1);
        check("halt_halted", int'(bus.halted), 1);
        check("halt_ticks", tick_seen - base, 1);
        bus.hlt = 1'b0;
        bus.push = 1'b1;
        wait_cycles(15);
        bus.push = 1'b0;
        bus.mode = 1'b0;
        wait_cycles(5);
        bus.mode = 1'b1;
        wait_cycles(5);
        bus.mode = 1'b0;
        wait_cycles(5);
        check("halt_sticky", int'(bus.halted), 1);
        check("halt_no_ticks", tick_seen - base, 1);
        check("halt_count", int'(bus.tick_count), 1);
        rst = 1'b1;
        wait_cycles(1);
        rst = 1'b0;
        wait_cycles(2);
        check("post_rst_halted", int'(bus.halted), 0);
        check("post_rst_count", int'(bus.tick_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
